// File: rtl/besdpb.sv
// besdpb: byte-enabled single-port RAM.
// One 32-bit word per address, byte-granular synchronous writes and a
// combinational read. An asynchronous active-low reset clears every word,
// which is what lets the cache treat all lines as invalid and clean after reset.
module besdpb #(
  parameter int ADDRESS_BITWIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [31:0]                 data_in,
  output logic [31:0]                 data_out
);

  localparam int DEPTH = 1 << ADDRESS_BITWIDTH;

  logic [31:0] mem [DEPTH];

  // Array update: clear everything on reset, otherwise merge the enabled bytes.
  // NOTE: clearing the whole array on reset rules out a RAM macro and maps the
  // storage onto resettable flops; that is intentional, because the cache relies
  // on every valid/dirty bit reading zero straight after reset.
  // NOTE: non-blocking assignments keep the read-during-write behaviour clean:
  // data_out shows the old word until the edge, then the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (write_enable[b]) begin
          mem[address][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  // Read path: pure combinational lookup, no enable and no output register.
  assign data_out = mem[address];

endmodule

// File: tb/tb_besdpb.sv
// tb_besdpb: scoreboard bench for besdpb.
// Stimulus drives writes/reads and pushes expected read data (from a plain
// word-array reference model) into a queue; a monitor pops and compares.
module tb_besdpb;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [3:0]    write_enable;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   expected;
    string         name;
  } exp_t;

  exp_t        exp_q[$];
  event        rd_ev;
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;

  besdpb #(.ADDRESS_BITWIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, actual, required);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [3:0] we,
                             input logic [31:0] d);
    logic [31:0] w;
    w = model[a];
    for (int b = 0; b < 4; b++) begin
      if (we[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    model[a] = w;
  endtask

  // Present an address and hand the expected word to the monitor.
  task automatic rd(input logic [AW-1:0] a, input string name);
    exp_t e;
    address = a;
    #1;
    e.addr     = a;
    e.expected = model[a];
    e.name     = name;
    exp_q.push_back(e);
    -> rd_ev;
    #1;
  endtask

  // Drive a write between edges, commit it at the rising edge.
  task automatic wr(input logic [AW-1:0] a, input logic [3:0] we,
                    input logic [31:0] d);
    @(negedge clk);
    address      = a;
    write_enable = we;
    data_in      = d;
    @(posedge clk);
    model_write(a, we, d);
    #1;
    write_enable = 4'b0000;
  endtask

  // Monitor: compare every queued expectation against the live output.
  initial begin
    exp_t e;
    forever begin
      @(rd_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s@%0d", e.name, e.addr), data_out, e.expected);
      end
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [31:0]   d;

    rst_n        = 1'b0;
    write_enable = 4'b0000;
    address      = '0;
    data_in      = '0;
    model_clear();
    #12;
    rd(8'd3, "reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clear, asynchronous, between edges.
    wr(8'd0,   4'b1111, 32'hDEAD_BEEF);
    wr(8'd1,   4'b1111, 32'hDEAD_BEEF);
    wr(8'd255, 4'b1111, 32'hDEAD_BEEF);
    rd(8'd255, "pre_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    rd(8'd0, "async_reset");
    #1;
    rst_n = 1'b1;
    rd(8'd0,   "reset_clear");
    rd(8'd1,   "reset_clear");
    rd(8'd255, "reset_clear");

    // Full word write/read.
    wr(8'd5, 4'b1111, 32'h1234_5678);
    rd(8'd5, "full_word");
    rd(8'd6, "neighbour");
    check("full_word_const", model[5], 32'h1234_5678);

    // Byte enables.
    wr(8'd5, 4'b0101, 32'hAABB_CCDD);
    rd(8'd5, "be_0101");
    check("be_0101_const", model[5], 32'h12BB_56DD);
    wr(8'd5, 4'b1000, 32'hAABB_CCDD);
    rd(8'd5, "be_1000");
    check("be_1000_const", model[5], 32'hAABB_56DD);

    // Zero enable on ten consecutive edges.
    for (int i = 0; i < 10; i++) wr(8'd5, 4'b0000, 32'hFFFF_FFFF);
    rd(8'd5, "zero_enable");

    // Read-during-write: old data before the edge, new data after.
    @(negedge clk);
    address      = 8'd7;
    write_enable = 4'b1111;
    data_in      = 32'h0000_0001;
    rd(8'd7, "rdw_before");
    @(posedge clk);
    model_write(8'd7, 4'b1111, 32'h0000_0001);
    #1;
    write_enable = 4'b0000;
    rd(8'd7, "rdw_after");

    // Boundary addresses.
    wr(8'd0,   4'b1111, 32'hA5A5_0000);
    wr(8'd255, 4'b1111, 32'h0000_5A5A);
    rd(8'd0,   "boundary");
    rd(8'd255, "boundary");
    rd(8'd128, "boundary_alias");

    // Randomized writes with random enables, interleaved with reads.
    for (int i = 0; i < 400; i++) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      we = 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 2) != 0) wr(a, we, d);
      rd(AW'($urandom_range(0, DEPTH - 1)), "random");
    end

    // Combinational sweep over the whole array.
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), "sweep");

    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
